addr_translate_tlb: RTL and testbench
=====================================

Name: addr_translate_tlb

Overview:
- Registered virtual-to-physical translator for the MIPS-style core, sitting between the fetch/memory stages and the bus interface.
- kseg0/kseg1 keep the fixed direct mapping; kuseg, kseg2 and kseg3 go through a parametrised, fully associative, software-managed TLB with ASID matching.
- Accepts one request per cycle via valid/ready and returns a registered response one cycle later, with miss/invalid/modified exception flags.
- Keeps a saturating count of TLB lookups that missed.

Parameters:
- NUM_ENTRIES, 8, number of TLB entries (power of two, 2..64).
- ASID_W, 8, ASID width in bits.
- CNT_W, 16, width of the miss counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous reset, active low.
- req_valid  in  1  translation request valid.
- req_ready  out  1  unit can accept a request this cycle.
- req_vaddr  in  32  virtual address.
- req_is_store  in  1  request is a store (dirty check).
- resp_valid  out  1  response register holds a result.
- resp_ready  in  1  consumer accepts the response.
- resp_paddr  out  32  physical address; 0 when any exception flag is set.
- resp_mapped  out  1  address went through the TLB.
- resp_miss  out  1  TLB refill exception.
- resp_invalid  out  1  matching entry has V=0.
- resp_modified  out  1  store to a matching entry with D=0.
- cur_asid  in  ASID_W  current address-space ID.
- tlb_we  in  1  write one entry.
- tlb_windex  in  $clog2(NUM_ENTRIES)  entry index to write.
- tlb_wvpn  in  20  virtual page number.
- tlb_wpfn  in  20  physical frame number.
- tlb_wasid  in  ASID_W  entry ASID.
- tlb_wg  in  1  global bit.
- tlb_wv  in  1  valid bit.
- tlb_wd  in  1  dirty bit.
- tlb_flush  in  1  clear all entry present bits.
- miss_count  out  CNT_W  saturating count of mapped requests that missed.

Behaviour:
- Reset (resetn low, asynchronous): resp_valid=0, resp_paddr=0, all resp flags=0, miss_count=0, all entry present bits (E)=0. Entry payloads are not reset.
- Handshake:
  - req_ready = !resp_valid || resp_ready (combinational).
  - A request is accepted when req_valid && req_ready; its response is registered at that edge, so latency is 1 cycle.
  - If resp_valid && !resp_ready, the response holds stable and req_ready=0.
  - If no request is accepted and resp_ready=1, resp_valid clears.
  - Back-to-back accepts at full throughput are supported.
- Segments, decoded on vaddr[31:28]:
  - 0x8, 0x9, 0xA, 0xB (unmapped): paddr = {3'b000, vaddr[28:0]}; resp_mapped=0; no flags; no TLB lookup.
  - All other values (mapped): resp_mapped=1; TLB lookup.
- TLB lookup:
  - Hit on entry i when E[i] && vpn[i]==vaddr[31:12] && (g[i] || asid[i]==cur_asid).
  - If multiple entries hit, the lowest index wins.
  - No hit: resp_miss=1.
  - Hit with v=0: resp_invalid=1.
  - Hit with v=1, req_is_store=1, d=0: resp_modified=1.
  - Otherwise: paddr = {pfn, vaddr[11:0]}.
  - At most one flag is set per response; paddr=0 whenever a flag is set.
- Table writes:
  - tlb_we writes all fields of entry tlb_windex and sets E=1 at the clock edge.
  - A lookup accepted in the same cycle as a write sees the old contents.
  - An already-registered response is never altered by a later write or flush.
- Flush:
  - tlb_flush clears every E bit at the edge.
  - If tlb_flush and tlb_we occur in the same cycle, the flush is applied first and the written entry ends with E=1.
- miss_count: increments by 1 on each accepted request that produces resp_miss; saturates at all-ones (no wrap).
- Reset asserted while a response is pending discards the response; no partial state remains after resetn rises.

Test Plan:
- Unmapped segments: reset, then send vaddr 0xBFC0_0000 followed by 0x8000_1234 with resp_ready=1 -> paddr 0x1FC0_0000 then 0x0000_1234; resp_valid asserted 1 cycle after each accept; mapped=0; no flags.
- Refill then hit:
  - Request 0x0040_0ABC with cur_asid=3 on an empty TLB -> resp_miss=1, paddr=0, miss_count=1.
  - Write index 2 with vpn 0x00400, pfn 0x12345, asid 3, g=0, v=1, d=1; repeat the request -> paddr 0x1234_5ABC.
- ASID and global:
  - Same entry, cur_asid=4 -> miss.
  - Rewrite the entry with g=1 -> hit, paddr 0x1234_5ABC.
  - Duplicate vpn at indices 1 and 5 with different pfn -> index 1 pfn returned.
- Invalid and modified:
  - Entry with v=0 -> resp_invalid=1.
  - Entry with v=1, d=0: load -> hit; store -> resp_modified=1, paddr=0.
- Backpressure:
  - Hold resp_ready=0 for 3 cycles with req_valid high -> req_ready=0; resp_paddr and flags stable.
  - Release -> next request accepted that cycle; response appears on the following cycle.
- Flush, write-collision and saturation:
  - Assert tlb_flush and tlb_we (index 0) in the same cycle -> only entry 0 hits afterwards.
  - With CNT_W=2, send 5 misses -> miss_count stops at 3.
  - Drop resetn mid-response -> resp_valid=0 immediately.

Source files
------------

// File: rtl/addr_translate_tlb.sv
// Registered virtual-to-physical address translator with a fully associative,
// software-managed TLB. kseg0/kseg1 map directly; every other segment is
// looked up in the TLB with ASID matching. Responses appear one cycle after
// the request is accepted and hold while the consumer stalls.
module addr_translate_tlb #(
  parameter  int NUM_ENTRIES = 8,
  parameter  int ASID_W      = 8,
  parameter  int CNT_W       = 16,
  localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_vaddr,
  input  logic              req_is_store,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_paddr,
  output logic              resp_mapped,
  output logic              resp_miss,
  output logic              resp_invalid,
  output logic              resp_modified,
  input  logic [ASID_W-1:0] cur_asid,
  input  logic              tlb_we,
  input  logic [IDX_W-1:0]  tlb_windex,
  input  logic [19:0]       tlb_wvpn,
  input  logic [19:0]       tlb_wpfn,
  input  logic [ASID_W-1:0] tlb_wasid,
  input  logic              tlb_wg,
  input  logic              tlb_wv,
  input  logic              tlb_wd,
  input  logic              tlb_flush,
  output logic [CNT_W-1:0]  miss_count
);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // TLB storage: present bits are reset, payload fields are not.
  logic [NUM_ENTRIES-1:0] e_q, e_d;
  logic [19:0]            vpn_q  [NUM_ENTRIES];
  logic [19:0]            vpn_d  [NUM_ENTRIES];
  logic [19:0]            pfn_q  [NUM_ENTRIES];
  logic [19:0]            pfn_d  [NUM_ENTRIES];
  logic [ASID_W-1:0]      asid_q [NUM_ENTRIES];
  logic [ASID_W-1:0]      asid_d [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] g_q, g_d, v_q, v_d, d_q, d_d;

  // Response and statistics registers.
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_paddr_q, resp_paddr_d;
  logic              resp_mapped_q, resp_mapped_d;
  logic              resp_miss_q, resp_miss_d;
  logic              resp_invalid_q, resp_invalid_d;
  logic              resp_modified_q, resp_modified_d;
  logic [CNT_W-1:0]  miss_count_q, miss_count_d;

  logic        accept;
  logic        seg_mapped;
  logic        hit;
  logic [19:0] hit_pfn;
  logic        hit_valid;
  logic        hit_dirty;

  assign req_ready  = !resp_valid_q || resp_ready;
  assign accept     = req_valid && req_ready;
  // 0x8..0xB on the top nibble is kseg0/kseg1, the only unmapped region.
  assign seg_mapped = (req_vaddr[31:30] != 2'b10);

  // Associative match; scanning upward and keeping the first hit gives the
  // lowest index priority when software has installed duplicates.
  always_comb begin
    hit       = 1'b0;
    hit_pfn   = '0;
    hit_valid = 1'b0;
    hit_dirty = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!hit && e_q[i] && (vpn_q[i] == req_vaddr[31:12]) &&
          (g_q[i] || (asid_q[i] == cur_asid))) begin
        hit       = 1'b1;
        hit_pfn   = pfn_q[i];
        hit_valid = v_q[i];
        hit_dirty = d_q[i];
      end
    end
  end

  // Table update: flush first so a simultaneous write leaves its entry present.
  always_comb begin
    e_d    = e_q;
    vpn_d  = vpn_q;
    pfn_d  = pfn_q;
    asid_d = asid_q;
    g_d    = g_q;
    v_d    = v_q;
    d_d    = d_q;
    if (tlb_flush) begin
      e_d = '0;
    end
    if (tlb_we) begin
      e_d[tlb_windex]    = 1'b1;
      vpn_d[tlb_windex]  = tlb_wvpn;
      pfn_d[tlb_windex]  = tlb_wpfn;
      asid_d[tlb_windex] = tlb_wasid;
      g_d[tlb_windex]    = tlb_wg;
      v_d[tlb_windex]    = tlb_wv;
      d_d[tlb_windex]    = tlb_wd;
    end
  end

  // Response formation: one exception flag at most, address zeroed on any flag.
  always_comb begin
    resp_valid_d    = resp_valid_q;
    resp_paddr_d    = resp_paddr_q;
    resp_mapped_d   = resp_mapped_q;
    resp_miss_d     = resp_miss_q;
    resp_invalid_d  = resp_invalid_q;
    resp_modified_d = resp_modified_q;
    miss_count_d    = miss_count_q;
    if (accept) begin
      resp_valid_d    = 1'b1;
      resp_paddr_d    = '0;
      resp_mapped_d   = seg_mapped;
      resp_miss_d     = 1'b0;
      resp_invalid_d  = 1'b0;
      resp_modified_d = 1'b0;
      if (!seg_mapped) begin
        resp_paddr_d = {3'b000, req_vaddr[28:0]};
      end else if (!hit) begin
        resp_miss_d  = 1'b1;
        miss_count_d = sat_inc(miss_count_q);
      end else if (!hit_valid) begin
        resp_invalid_d = 1'b1;
      end else if (req_is_store && !hit_dirty) begin
        resp_modified_d = 1'b1;
      end else begin
        resp_paddr_d = {hit_pfn, req_vaddr[11:0]};
      end
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  // Control and response state with asynchronous reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_q             <= '0;
      resp_valid_q    <= 1'b0;
      resp_paddr_q    <= '0;
      resp_mapped_q   <= 1'b0;
      resp_miss_q     <= 1'b0;
      resp_invalid_q  <= 1'b0;
      resp_modified_q <= 1'b0;
      miss_count_q    <= '0;
    end else begin
      e_q             <= e_d;
      resp_valid_q    <= resp_valid_d;
      resp_paddr_q    <= resp_paddr_d;
      resp_mapped_q   <= resp_mapped_d;
      resp_miss_q     <= resp_miss_d;
      resp_invalid_q  <= resp_invalid_d;
      resp_modified_q <= resp_modified_d;
      miss_count_q    <= miss_count_d;
    end
  end

  // Entry payload storage, only meaningful while the present bit is set.
  always_ff @(posedge clk) begin
    vpn_q  <= vpn_d;
    pfn_q  <= pfn_d;
    asid_q <= asid_d;
    g_q    <= g_d;
    v_q    <= v_d;
    d_q    <= d_d;
  end

  assign resp_valid    = resp_valid_q;
  assign resp_paddr    = resp_paddr_q;
  assign resp_mapped   = resp_mapped_q;
  assign resp_miss     = resp_miss_q;
  assign resp_invalid  = resp_invalid_q;
  assign resp_modified = resp_modified_q;
  assign miss_count    = miss_count_q;

endmodule

// File: tb/tb_addr_translate_tlb.sv
// Directed testbench for addr_translate_tlb: a vector table for steady-state
// translations plus hand-written sequences for handshake, write ordering,
// flush, reset and counter saturation.
module tb_addr_translate_tlb;

  localparam int NUM_ENTRIES = 8;
  localparam int ASID_W      = 8;
  localparam int CNT_W       = 2;
  localparam int IDX_W       = $clog2(NUM_ENTRIES);

  logic              clk = 1'b0;
  logic              resetn;
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_vaddr;
  logic              req_is_store;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_paddr;
  logic              resp_mapped;
  logic              resp_miss;
  logic              resp_invalid;
  logic              resp_modified;
  logic [ASID_W-1:0] cur_asid;
  logic              tlb_we;
  logic [IDX_W-1:0]  tlb_windex;
  logic [19:0]       tlb_wvpn;
  logic [19:0]       tlb_wpfn;
  logic [ASID_W-1:0] tlb_wasid;
  logic              tlb_wg;
  logic              tlb_wv;
  logic              tlb_wd;
  logic              tlb_flush;
  logic [CNT_W-1:0]  miss_count;

  addr_translate_tlb #(
    .NUM_ENTRIES(NUM_ENTRIES),
    .ASID_W(ASID_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vaddr(req_vaddr), .req_is_store(req_is_store),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_paddr(resp_paddr), .resp_mapped(resp_mapped),
    .resp_miss(resp_miss), .resp_invalid(resp_invalid),
    .resp_modified(resp_modified), .cur_asid(cur_asid),
    .tlb_we(tlb_we), .tlb_windex(tlb_windex), .tlb_wvpn(tlb_wvpn),
    .tlb_wpfn(tlb_wpfn), .tlb_wasid(tlb_wasid), .tlb_wg(tlb_wg),
    .tlb_wv(tlb_wv), .tlb_wd(tlb_wd), .tlb_flush(tlb_flush),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // flags = {mapped, miss, invalid, modified}
  typedef struct {
    logic [31:0]       va;
    logic              st;
    logic [ASID_W-1:0] asid;
    logic [31:0]       pa;
    logic [3:0]        flags;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  int n_chk  = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Checks a freshly registered response and tracks the expected miss count.
  task automatic check_resp(input string name, input logic [31:0] pa, input logic [3:0] flags);
    if (flags[2] && exp_cnt < 3) exp_cnt++;
    chk({name, ".valid"}, {31'b0, resp_valid}, 32'd1);
    chk({name, ".paddr"}, resp_paddr, pa);
    chk({name, ".flags"}, {28'b0, resp_mapped, resp_miss, resp_invalid, resp_modified},
        {28'b0, flags});
    chk({name, ".cnt"}, {30'b0, miss_count}, exp_cnt);
  endtask

  // Entered and left at one time unit after a rising edge.
  task automatic send(input logic [31:0] va, input logic st);
    req_valid    = 1'b1;
    req_vaddr    = va;
    req_is_store = st;
    @(posedge clk); #1;
    req_valid    = 1'b0;
  endtask

  task automatic set_entry(input int idx, input logic [19:0] vpn, input logic [19:0] pfn,
                           input logic [ASID_W-1:0] asid, input logic g, input logic v,
                           input logic d);
    tlb_windex = IDX_W'(idx);
    tlb_wvpn   = vpn;
    tlb_wpfn   = pfn;
    tlb_wasid  = asid;
    tlb_wg     = g;
    tlb_wv     = v;
    tlb_wd     = d;
  endtask

  task automatic write_entry(input int idx, input logic [19:0] vpn, input logic [19:0] pfn,
                             input logic [ASID_W-1:0] asid, input logic g, input logic v,
                             input logic d);
    set_entry(idx, vpn, pfn, asid, g, v, d);
    tlb_we = 1'b1;
    @(posedge clk); #1;
    tlb_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{32'h1000_0123, 1'b0, 8'd4, 32'hAAAA_A123, 4'b1000};
    vecs[1]  = '{32'h2000_0FFF, 1'b0, 8'd4, 32'h0000_0000, 4'b1010};
    vecs[2]  = '{32'hC000_0010, 1'b0, 8'd4, 32'h4444_4010, 4'b1000};
    vecs[3]  = '{32'hC000_0010, 1'b1, 8'd4, 32'h0000_0000, 4'b1001};
    vecs[4]  = '{32'h0040_0ABC, 1'b1, 8'd4, 32'h1234_5ABC, 4'b1000};
    vecs[5]  = '{32'h0040_1000, 1'b0, 8'd7, 32'h6666_6000, 4'b1000};
    vecs[6]  = '{32'h0040_1000, 1'b0, 8'd8, 32'h0000_0000, 4'b1100};
    vecs[7]  = '{32'hA000_0040, 1'b0, 8'd8, 32'h0000_0040, 4'b0000};
    vecs[8]  = '{32'h9FFF_FFFC, 1'b1, 8'd8, 32'h1FFF_FFFC, 4'b0000};
    vecs[9]  = '{32'h7FFF_F000, 1'b0, 8'd8, 32'h0000_0000, 4'b1100};
    vecs[10] = '{32'hE000_0000, 1'b0, 8'd8, 32'h0000_0000, 4'b1100};
    vecs[11] = '{32'h2000_0FFF, 1'b1, 8'd4, 32'h0000_0000, 4'b1010};

    resetn = 1'b0; req_valid = 1'b0; req_vaddr = '0; req_is_store = 1'b0;
    resp_ready = 1'b1; cur_asid = '0; tlb_we = 1'b0; tlb_flush = 1'b0;
    set_entry(0, '0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", {31'b0, resp_valid}, 32'd0);
    chk("rst.paddr", resp_paddr, 32'd0);
    chk("rst.flags", {28'b0, resp_mapped, resp_miss, resp_invalid, resp_modified}, 32'd0);
    chk("rst.cnt", {30'b0, miss_count}, 32'd0);
    chk("rst.ready", {31'b0, req_ready}, 32'd1);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Unmapped segments, back to back
    send(32'hBFC0_0000, 1'b0);
    check_resp("kseg1", 32'h1FC0_0000, 4'b0000);
    send(32'h8000_1234, 1'b0);
    check_resp("kseg0", 32'h0000_1234, 4'b0000);

    // Refill then hit
    cur_asid = 8'd3;
    send(32'h0040_0ABC, 1'b0);
    check_resp("refill", 32'h0, 4'b1100);
    write_entry(2, 20'h00400, 20'h12345, 8'd3, 1'b0, 1'b1, 1'b1);
    send(32'h0040_0ABC, 1'b0);
    check_resp("hit", 32'h1234_5ABC, 4'b1000);

    // ASID mismatch, then global
    cur_asid = 8'd4;
    send(32'h0040_0ABC, 1'b0);
    check_resp("asid_miss", 32'h0, 4'b1100);
    write_entry(2, 20'h00400, 20'h12345, 8'd3, 1'b1, 1'b1, 1'b1);
    send(32'h0040_0ABC, 1'b0);
    check_resp("global", 32'h1234_5ABC, 4'b1000);

    // Table-driven translations
    write_entry(1, 20'h10000, 20'hAAAAA, 8'd4, 1'b1, 1'b1, 1'b1);
    write_entry(5, 20'h10000, 20'hBBBBB, 8'd4, 1'b1, 1'b1, 1'b1);
    write_entry(3, 20'h20000, 20'h33333, 8'd0, 1'b1, 1'b0, 1'b1);
    write_entry(4, 20'hC0000, 20'h44444, 8'd0, 1'b1, 1'b1, 1'b0);
    write_entry(6, 20'h00401, 20'h66666, 8'd7, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < NVEC; i++) begin
      cur_asid = vecs[i].asid;
      send(vecs[i].va, vecs[i].st);
      check_resp($sformatf("vec%0d", i), vecs[i].pa, vecs[i].flags);
    end

    // Backpressure: response holds while a later write changes its entry
    cur_asid = 8'd4;
    send(32'hC000_0010, 1'b0);
    check_resp("bp.first", 32'h4444_4010, 4'b1000);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_vaddr = 32'h0040_0ABC; req_is_store = 1'b0;
    set_entry(4, 20'hC0000, 20'h77777, 8'd0, 1'b1, 1'b1, 1'b1);
    tlb_we = 1'b1;
    #1;
    chk("bp.ready0", {31'b0, req_ready}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      tlb_we = 1'b0;
      chk($sformatf("bp.hold%0d.ready", c), {31'b0, req_ready}, 32'd0);
      chk($sformatf("bp.hold%0d.valid", c), {31'b0, resp_valid}, 32'd1);
      chk($sformatf("bp.hold%0d.paddr", c), resp_paddr, 32'h4444_4010);
      chk($sformatf("bp.hold%0d.flags", c),
          {28'b0, resp_mapped, resp_miss, resp_invalid, resp_modified}, 32'h8);
    end
    resp_ready = 1'b1;
    #1;
    chk("bp.release.ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_resp("bp.next", 32'h1234_5ABC, 4'b1000);
    send(32'hC000_0010, 1'b0);
    check_resp("bp.newpfn", 32'h7777_7010, 4'b1000);

    // Flush and write in the same cycle: only the written entry survives
    set_entry(0, 20'h00500, 20'h55555, 8'd0, 1'b1, 1'b1, 1'b1);
    tlb_we = 1'b1; tlb_flush = 1'b1;
    @(posedge clk); #1;
    tlb_we = 1'b0; tlb_flush = 1'b0;
    send(32'h0050_0004, 1'b0);
    check_resp("flush.kept", 32'h5555_5004, 4'b1000);
    send(32'h1000_0123, 1'b0);
    check_resp("flush.gone1", 32'h0, 4'b1100);
    send(32'h0040_0ABC, 1'b0);
    check_resp("flush.gone2", 32'h0, 4'b1100);

    // Lookup in the same cycle as a write sees the old table
    set_entry(7, 20'h00600, 20'h60606, 8'd0, 1'b1, 1'b1, 1'b1);
    tlb_we = 1'b1;
    send(32'h0060_0000, 1'b0);
    tlb_we = 1'b0;
    check_resp("wcol.old", 32'h0, 4'b1100);
    send(32'h0060_0000, 1'b0);
    check_resp("wcol.new", 32'h6060_6000, 4'b1000);

    // Reset while a response is pending
    send(32'h0060_0000, 1'b0);
    resp_ready = 1'b0;
    check_resp("prerst", 32'h6060_6000, 4'b1000);
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst.valid", {31'b0, resp_valid}, 32'd0);
    chk("midrst.paddr", resp_paddr, 32'd0);
    chk("midrst.cnt", {30'b0, miss_count}, 32'd0);
    exp_cnt = 0;
    @(negedge clk);
    resetn = 1'b1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("postrst.valid", {31'b0, resp_valid}, 32'd0);

    // Miss counter saturation (entries were cleared by reset)
    for (int k = 0; k < 5; k++) begin
      send(32'h0060_0000, 1'b0);
      check_resp($sformatf("sat%0d", k), 32'h0, 4'b1100);
    end
    chk("sat.final", {30'b0, miss_count}, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
